// File: rtl/audio_fx_pkg.sv
// rtl/audio_fx_pkg.sv - shared widths, FSM encoding and saturation helper for the echo effect
package audio_fx_pkg;

  localparam int SAMPLE_W = 16;
  localparam int FRAME_W  = 32;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_READ,
    ST_MIX,
    ST_WRITE
  } state_e;

  // Differing top two bits means the 17-bit sum left the 16-bit range.
  function automatic logic [SAMPLE_W-1:0] sat16(input logic signed [SAMPLE_W:0] x);
    if (x[SAMPLE_W] != x[SAMPLE_W-1]) begin
      return x[SAMPLE_W] ? 16'h8000 : 16'h7fff;
    end
    return x[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// rtl/echo_delay_ram.sv - simple dual-port frame buffer, registered read, contents not reset
module echo_delay_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/audio_echo_delay.sv
// rtl/audio_echo_delay.sv - stereo echo/delay: circular frame buffer with wet mix and decaying feedback
module audio_echo_delay
  import audio_fx_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int WET_SHIFT = 1,
  parameter int FB_SHIFT  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [FRAME_W-1:0] in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               en_i,
  input  logic [ADDR_W-1:0]  delay_i,
  output logic [FRAME_W-1:0] out_data_o,
  output logic               out_valid_o,
  output logic               overrun_o
);

  state_e             state_q;
  logic [ADDR_W-1:0]  wr_ptr_q;
  logic [ADDR_W-1:0]  clr_addr_q;
  logic [FRAME_W-1:0] dry_q;
  logic               bypass_q;
  logic [FRAME_W-1:0] out_q;
  logic [FRAME_W-1:0] fb_q;
  logic [FRAME_W-1:0] out_data_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic               overrun_q;

  logic               accept;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr;
  logic [FRAME_W-1:0] ram_wdata;
  logic [ADDR_W-1:0]  ram_raddr;
  logic [FRAME_W-1:0] wet;
  logic [FRAME_W-1:0] out_d;
  logic [FRAME_W-1:0] fb_d;

  function automatic logic [SAMPLE_W-1:0] mix_lane(input logic [SAMPLE_W-1:0] dry,
                                                   input logic [SAMPLE_W-1:0] tap,
                                                   input int sh);
    logic signed [SAMPLE_W-1:0] atten;
    logic signed [SAMPLE_W:0]   sum;
    atten = $signed(tap) >>> sh;
    sum   = $signed({dry[SAMPLE_W-1], dry}) + $signed({atten[SAMPLE_W-1], atten});
    return sat16(sum);
  endfunction

  assign accept    = (state_q == ST_IDLE) && in_ready_q && in_valid_i;
  assign ram_we    = (state_q == ST_CLEAR) || (state_q == ST_WRITE);
  assign ram_waddr = (state_q == ST_CLEAR) ? clr_addr_q : wr_ptr_q;
  assign ram_wdata = (state_q == ST_CLEAR) ? '0 : fb_q;
  assign ram_raddr = wr_ptr_q - delay_i;

  echo_delay_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (FRAME_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (accept),
    .raddr_i (ram_raddr),
    .rdata_o (wet)
  );

  // Lanes are mixed independently so no carry crosses from right into left.
  always_comb begin
    out_d = dry_q;
    fb_d  = dry_q;
    if (!bypass_q) begin
      out_d = {mix_lane(dry_q[31:16], wet[31:16], WET_SHIFT),
               mix_lane(dry_q[15:0],  wet[15:0],  WET_SHIFT)};
      fb_d  = {mix_lane(dry_q[31:16], wet[31:16], FB_SHIFT),
               mix_lane(dry_q[15:0],  wet[15:0],  FB_SHIFT)};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_CLEAR;
      wr_ptr_q    <= '0;
      clr_addr_q  <= '0;
      dry_q       <= '0;
      bypass_q    <= 1'b1;
      out_q       <= '0;
      fb_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (in_valid_i && !in_ready_q && (state_q != ST_CLEAR)) overrun_q <= 1'b1;
      case (state_q)
        ST_CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == '1) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
          end
        end
        // Ready returns one edge after the output strobe, not on re-entry to IDLE.
        ST_IDLE: begin
          if (!in_ready_q) begin
            in_ready_q <= 1'b1;
          end else if (in_valid_i) begin
            dry_q      <= in_data_i;
            bypass_q   <= !en_i || (delay_i == '0);
            in_ready_q <= 1'b0;
            state_q    <= ST_READ;
          end
        end
        ST_READ: state_q <= ST_MIX;
        ST_MIX: begin
          out_q   <= out_d;
          fb_q    <= fb_d;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          wr_ptr_q    <= wr_ptr_q + 1'b1;
          out_data_q  <= out_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_audio_echo_delay.sv
// tb/tb_audio_echo_delay.sv - directed self-checking bench for audio_echo_delay (8-frame buffer)
module tb_audio_echo_delay;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          en = 1'b0;
  logic [AW-1:0] delay = '0;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int out_pulses = 0;

  audio_echo_delay #(
    .ADDR_W    (AW),
    .WET_SHIFT (1),
    .FB_SHIFT  (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .en_i        (en),
    .delay_i     (delay),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid) out_pulses++;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(output int cycles);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycles = 0;
    for (int i = 0; i < DEPTH + 6; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (in_ready) break;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic e, input int dl,
                      output logic [31:0] got, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    in_data  = d;
    en       = e;
    delay    = dl[AW-1:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    got = 32'hxxxx_xxxx;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        got = out_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cycles;
    logic [31:0] got;
    int lat;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_data, out_valid, in_ready, overrun} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h/%b/%b/%b want=0/0/0/0", out_data, out_valid, in_ready, overrun);
    end
    rst = 1'b0;
    cycles = 0;
    for (int i = 0; i < DEPTH + 6; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 2) in_valid = 1'b1;
      if (cycles == 3) in_valid = 1'b0;
      if (in_ready) break;
    end
    n_cmp++;
    if (cycles !== DEPTH) begin
      n_bad++;
      $display("FAIL clear_length got=%0d want=%0d", cycles, DEPTH);
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_no_overrun got=%b want=0", overrun);
    end
    for (int f = 0; f < DEPTH; f++) begin
      send(32'h0, 1'b1, 7, got, lat);
      n_cmp++;
      if (got !== 32'h0) begin
        n_bad++;
        $display("FAIL ram_zero frame=%0d got=%h want=00000000", f, got);
      end
    end
  endtask

  task automatic test_impulse();
    int cycles, lat;
    logic [31:0] got, want;
    do_reset(cycles);
    for (int f = 0; f <= 8; f++) begin
      send((f == 0) ? 32'h4000_C000 : 32'h0, 1'b1, 4, got, lat);
      want = (f == 0) ? 32'h4000_C000 : (f == 4) ? 32'h2000_E000 : (f == 8) ? 32'h0800_F800 : 32'h0;
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL impulse frame=%0d got=%h want=%h", f, got, want);
      end
      if (f == 0) begin
        n_cmp++;
        if (lat !== 3) begin
          n_bad++;
          $display("FAIL impulse_latency got=%0d want=3", lat);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int cycles, lat;
    logic [31:0] got;
    logic [31:0] want [3];
    want[0] = 32'h7000_9000;
    want[1] = 32'h7FFF_8000;
    want[2] = 32'h3FFF_C000;
    do_reset(cycles);
    for (int f = 0; f < 3; f++) begin
      send((f < 2) ? 32'h7000_9000 : 32'h0, 1'b1, 1, got, lat);
      n_cmp++;
      if (got !== want[f]) begin
        n_bad++;
        $display("FAIL saturation frame=%0d got=%h want=%h", f, got, want[f]);
      end
    end
  endtask

  task automatic test_bypass();
    int lat;
    logic [31:0] got;
    logic [31:0] vec [5];
    vec[0] = 32'h1234_5678;
    vec[1] = 32'h8000_7FFF;
    vec[2] = 32'hFFFF_0001;
    vec[3] = 32'hDEAD_BEEF;
    vec[4] = 32'h0102_0304;
    for (int f = 0; f < 5; f++) begin
      send(vec[f], (f == 4), (f == 4) ? 0 : 3, got, lat);
      n_cmp++;
      if (got !== vec[f] || lat !== 3) begin
        n_bad++;
        $display("FAIL bypass frame=%0d got=%h lat=%0d want=%h lat=3", f, got, lat, vec[f]);
      end
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL bypass_overrun got=%b want=0", overrun);
    end
    send(32'h0, 1'b1, 1, got, lat);
    n_cmp++;
    if (got !== 32'h0081_0182) begin
      n_bad++;
      $display("FAIL bypass_stored_dry got=%h want=00810182", got);
    end
  endtask

  task automatic test_overrun();
    int w, lat;
    logic [31:0] got;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    out_pulses = 0;
    en       = 1'b0;
    in_data  = 32'h1111_2222;
    in_valid = 1'b1;
    @(negedge clk);
    in_data  = 32'h3333_4444;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (out_pulses !== 1 || out_data !== 32'h1111_2222) begin
      n_bad++;
      $display("FAIL overrun_single_out got=%0d/%h want=1/11112222", out_pulses, out_data);
    end
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_set got=%b want=1", overrun);
    end
    send(32'h5555_6666, 1'b0, 2, got, lat);
    n_cmp++;
    if (overrun !== 1'b1 || got !== 32'h5555_6666) begin
      n_bad++;
      $display("FAIL overrun_sticky got=%b/%h want=1/55556666", overrun, got);
    end
  endtask

  task automatic test_wrap();
    int cycles, lat;
    logic [31:0] got, want;
    do_reset(cycles);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_cleared got=%b want=0", overrun);
    end
    for (int f = 0; f < 20; f++) begin
      send((f == 0) ? 32'h4000_C000 : 32'h0, 1'b1, 7, got, lat);
      want = (f == 0) ? 32'h4000_C000 : (f == 7) ? 32'h2000_E000 : (f == 14) ? 32'h0800_F800 : 32'h0;
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL wrap frame=%0d got=%h want=%h", f, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w, cycles, lat;
    logic [31:0] got;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    out_pulses = 0;
    in_data  = 32'h7777_1111;
    en       = 1'b1;
    delay    = 3'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs got=%b/%h want=0/00000000", in_ready, out_data);
    end
    rst = 1'b0;
    cycles = 0;
    for (int i = 0; i < DEPTH + 6; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (in_ready) break;
    end
    n_cmp++;
    if (cycles !== DEPTH) begin
      n_bad++;
      $display("FAIL reset_mid_clear got=%0d want=%0d", cycles, DEPTH);
    end
    n_cmp++;
    if (out_pulses !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_no_out got=%0d want=0", out_pulses);
    end
    send(32'h0, 1'b1, 1, got, lat);
    n_cmp++;
    if (got !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mid_ram_clear got=%h want=00000000", got);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_bypass();
    test_overrun();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
